md_unit: RTL and testbench

Multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the execute stage. It accepts the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO operations that decode tags onto `alu_op`, owns the HI/LO registers, and reports a multi-cycle busy window that the hazard logic uses to stall later HI/LO consumers in decode.

---
 rtl/md_unit_pkg.sv | 18 +
 rtl/md_unit_if.sv | 17 +
 rtl/md_calc.sv | 43 ++++
 rtl/md_unit.sv | 98 +++++++++
 tb/tb_md_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared MD-unit definitions: ALU op codes used by decode, cycle counts, FSM states.
package md_unit_pkg;
   localparam int ALU_OP_LEN = 5;

   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULT  = 5'd16;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULTU = 5'd17;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIV   = 5'd18;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIVU  = 5'd19;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFHI  = 5'd20;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFLO  = 5'd21;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTHI  = 5'd22;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTLO  = 5'd23;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
endpackage

// File: rtl/md_unit_if.sv
// Execute-stage <-> MD unit bundle; slave is the MD unit, master is the pipeline.
interface md_unit_if;
   import md_unit_pkg::*;

   logic                  valid;
   logic [ALU_OP_LEN-1:0] op;
   logic [31:0]           a;
   logic [31:0]           b;
   logic                  start;
   logic                  busy;
   logic [31:0]           hi;
   logic [31:0]           lo;
   logic [31:0]           read_data;

   modport slave  (input valid, op, a, b, output start, busy, hi, lo, read_data);
   modport master (output valid, op, a, b, input start, busy, hi, lo, read_data);
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath; result is latched by md_unit on start.
module md_calc
   import md_unit_pkg::*;
(
   input  logic [ALU_OP_LEN-1:0] op_i,
   input  logic [31:0]           a_i,
   input  logic [31:0]           b_i,
   output logic [31:0]           res_hi_o,
   output logic [31:0]           res_lo_o,
   output logic                  div_zero_o
);
   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] b_div;
   logic signed [31:0] q_s, r_s;
   logic        [31:0] q_u, r_u;
   logic               ovf;

   always_comb begin
      a_sx   = {{32{a_i[31]}}, a_i};
      b_sx   = {{32{b_i[31]}}, b_i};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, a_i} * {32'd0, b_i};
      // Divide by 1 on zero divisor and on INT_MIN/-1: gives the wrapped quotient with remainder 0
      ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
      b_div  = ((b_i == 32'd0) || ovf) ? 32'd1 : b_i;
      q_s    = $signed(a_i) / $signed(b_div);
      r_s    = $signed(a_i) % $signed(b_div);
      q_u    = a_i / b_div;
      r_u    = a_i % b_div;

      res_hi_o   = 32'd0;
      res_lo_o   = 32'd0;
      div_zero_o = 1'b0;
      case (op_i)
         ALU_OP_MULT:  begin res_hi_o = prod_s[63:32]; res_lo_o = prod_s[31:0]; end
         ALU_OP_MULTU: begin res_hi_o = prod_u[63:32]; res_lo_o = prod_u[31:0]; end
         ALU_OP_DIV:   begin res_hi_o = r_s; res_lo_o = q_s; div_zero_o = (b_i == 32'd0); end
         ALU_OP_DIVU:  begin res_hi_o = r_u; res_lo_o = q_u; div_zero_o = (b_i == 32'd0); end
         default: ;
      endcase
   end
endmodule

// File: rtl/md_unit.sv
// MD unit: owns HI/LO, models multi-cycle MULT/DIV latency with a busy window for hazard logic.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
   input  logic      clk,
   input  logic      reset_n,
   md_unit_if.slave  md
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_dz_q, pend_dz_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;

   logic [31:0] res_hi, res_lo;
   logic        div_zero, is_mul, is_div;

   md_calc u_calc (
      .op_i       (md.op),
      .a_i        (md.a),
      .b_i        (md.b),
      .res_hi_o   (res_hi),
      .res_lo_o   (res_lo),
      .div_zero_o (div_zero)
   );

   assign is_mul       = (md.op == ALU_OP_MULT) || (md.op == ALU_OP_MULTU);
   assign is_div       = (md.op == ALU_OP_DIV)  || (md.op == ALU_OP_DIVU);
   assign md.start     = md.valid && (is_mul || is_div) && (state_q == MD_IDLE);
   assign md.busy      = (state_q == MD_RUN);
   assign md.hi        = hi_q;
   assign md.lo        = lo_q;
   assign md.read_data = (md.op == ALU_OP_MFHI) ? hi_q :
                         (md.op == ALU_OP_MFLO) ? lo_q : 32'd0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (md.start) begin
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               pend_dz_d = div_zero;
               cnt_d     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               state_d   = MD_RUN;
            end else if (md.valid && md.op == ALU_OP_MTHI) begin
               hi_d = md.a;
            end else if (md.valid && md.op == ALU_OP_MTLO) begin
               lo_d = md.a;
            end
         end
         MD_RUN: begin
            // Last busy cycle: commit so the new HI/LO appear together with busy falling
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = MD_IDLE;
               if (!pend_dz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_dz_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected commits/reads, a monitor checks them.
module tb_md_unit;
   import md_unit_pkg::*;

   typedef struct {
      logic [31:0] pre_hi, pre_lo, hi, lo;
      int          n;
   } item_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rd_chk = 1'b0;
   int   nchk = 0;
   int   nerr = 0;

   item_t       exp_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] mdl_hi = 32'd0, mdl_lo = 32'd0;

   md_unit_if mif();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .md      (mif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: busy window length, HI/LO stability while busy, commit values, reads
   bit  in_run = 0;
   int  bcnt = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         in_run = 0;
      end else begin
         if (mif.busy) begin
            if (!in_run) begin
               in_run = 1;
               bcnt = 0;
               if (exp_q.size() == 0) chk("unexpected_busy", 32'd1, 32'd0);
            end
            bcnt++;
            if (exp_q.size() != 0) begin
               chk("hi_stable", mif.hi, exp_q[0].pre_hi);
               chk("lo_stable", mif.lo, exp_q[0].pre_lo);
            end
         end else if (in_run) begin
            in_run = 0;
            if (exp_q.size() != 0) begin
               item_t it;
               it = exp_q.pop_front();
               chk("busy_len", bcnt, it.n);
               chk("commit_hi", mif.hi, it.hi);
               chk("commit_lo", mif.lo, it.lo);
            end
         end
         if (rd_chk && rd_q.size() != 0) chk("read_data", mif.read_data, rd_q.pop_front());
      end
   end

   task automatic drive(input logic v, input logic [ALU_OP_LEN-1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      mif.valid = v; mif.op = op; mif.a = a; mif.b = b;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_commit(input int n);
      for (int i = 0; i < n + 4 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         chk("commit_timeout", 32'd1, 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic md_op(input logic [ALU_OP_LEN-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int n, input bit dz);
      item_t it;
      it.pre_hi = mdl_hi; it.pre_lo = mdl_lo; it.n = n;
      if (!dz) begin mdl_hi = eh; mdl_lo = el; end
      it.hi = mdl_hi; it.lo = mdl_lo;
      exp_q.push_back(it);
      drive(1'b1, op, a, b);
      @(negedge clk); chk("start", {31'd0, mif.start}, 32'd1);
      step();
      drive(1'b0, ALU_OP_MFLO, 32'd0, 32'd0);
      wait_commit(n);
   endtask

   task automatic mt_mf(input logic [ALU_OP_LEN-1:0] mt, input logic [ALU_OP_LEN-1:0] mf,
                        input logic [31:0] v);
      drive(1'b1, mt, v, 32'd0);
      if (mt == ALU_OP_MTHI) mdl_hi = v; else mdl_lo = v;
      step();
      rd_q.push_back(v);
      drive(1'b1, mf, 32'd0, 32'd0); rd_chk = 1'b1;
      step();
      rd_chk = 1'b0; drive(1'b0, ALU_OP_MULT, 32'd0, 32'd0);
   endtask

   initial begin
      drive(1'b0, ALU_OP_MULT, 32'd0, 32'd0);
      #3;
      chk("rst_hi", mif.hi, 32'd0);
      chk("rst_lo", mif.lo, 32'd0);
      chk("rst_busy", {31'd0, mif.busy}, 32'd0);
      @(negedge clk); #2 reset_n = 1'b1;
      step();

      md_op(ALU_OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0);
      md_op(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 0);
      md_op(ALU_OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
      md_op(ALU_OP_DIVU,  32'd7,         32'd0, 32'd0,         32'd0,         10, 1);
      md_op(ALU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);
      md_op(ALU_OP_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd0, 5, 0);

      mt_mf(ALU_OP_MTHI, ALU_OP_MFHI, 32'h1234_5678);
      mt_mf(ALU_OP_MTLO, ALU_OP_MFLO, 32'hCAFE_F00D);

      // MTHI with valid=0 must not write; non-MF op reads back zero
      drive(1'b0, ALU_OP_MTHI, 32'hFFFF_0000, 32'd0);
      step();
      rd_q.push_back(mdl_hi); drive(1'b1, ALU_OP_MFHI, 32'd0, 32'd0); rd_chk = 1'b1;
      step();
      rd_q.push_back(32'd0); drive(1'b0, ALU_OP_MTLO, 32'd0, 32'd0);
      step();
      rd_chk = 1'b0;

      // MULT, then MTLO and a second MULT while busy: both ignored
      begin
         item_t it;
         it.pre_hi = mdl_hi; it.pre_lo = mdl_lo; it.n = 5;
         mdl_hi = 32'd0; mdl_lo = 32'd15;
         it.hi = mdl_hi; it.lo = mdl_lo;
         exp_q.push_back(it);
      end
      drive(1'b1, ALU_OP_MULT, 32'd3, 32'd5);
      step();
      drive(1'b0, ALU_OP_MULT, 32'd0, 32'd0);
      step();
      drive(1'b1, ALU_OP_MTLO, 32'h0000_DEAD, 32'd0);
      @(negedge clk); chk("start_busy_mt", {31'd0, mif.start}, 32'd0);
      step();
      drive(1'b1, ALU_OP_MULT, 32'd7, 32'd7);
      @(negedge clk); chk("start_busy_mult", {31'd0, mif.start}, 32'd0);
      step();
      drive(1'b0, ALU_OP_MULT, 32'd0, 32'd0);
      wait_commit(5);

      drive(1'b0, ALU_OP_MULT, 32'd9, 32'd9);
      @(negedge clk); chk("start_novalid", {31'd0, mif.start}, 32'd0);
      step(); step();
      chk("busy_novalid", {31'd0, mif.busy}, 32'd0);

      // Reset mid-DIV: outputs clear at once, nothing commits afterwards
      begin
         item_t it;
         it.pre_hi = mdl_hi; it.pre_lo = mdl_lo; it.n = 10;
         it.hi = 32'd2; it.lo = 32'd14;
         exp_q.push_back(it);
      end
      drive(1'b1, ALU_OP_DIV, 32'd100, 32'd7);
      step();
      drive(1'b0, ALU_OP_MULT, 32'd0, 32'd0);
      step(); step();
      @(posedge clk); #3 reset_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, mif.busy}, 32'd0);
      chk("arst_hi", mif.hi, 32'd0);
      chk("arst_lo", mif.lo, 32'd0);
      exp_q.delete();
      mdl_hi = 32'd0; mdl_lo = 32'd0;
      @(negedge clk); @(negedge clk); #2 reset_n = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      chk("post_rst_busy", {31'd0, mif.busy}, 32'd0);
      chk("post_rst_hi", mif.hi, 32'd0);
      chk("post_rst_lo", mif.lo, 32'd0);

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
